// File: rtl/alu4_pkg.sv
// Shared types and constants for the alu4 issue/retire stage.
package alu4_pkg;

  localparam int unsigned ALU4_FIFO_DEPTH   = 2;
  localparam int unsigned ALU4_FIFO_PTR_W   = 1;
  localparam int unsigned ALU4_FIFO_CNT_W   = 2;
  localparam int unsigned ALU4_OPND_W       = 4;
  localparam int unsigned ALU4_OP_W         = 2;
  localparam int unsigned ALU4_RES_W        = 8;
  localparam int unsigned ALU4_NUM_OPS      = 4;
  localparam int unsigned ALU4_STATS_CNT_W  = 8;

  typedef enum logic [ALU4_OP_W-1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_RSVD = 2'b10,
    OP_MUL  = 2'b11
  } alu4_op_e;

  typedef struct packed {
    logic [ALU4_OPND_W-1:0] a;
    logic [ALU4_OPND_W-1:0] b;
    logic [ALU4_OP_W-1:0]   op;
  } alu4_req_t;

endpackage

// File: rtl/alu4_req_fifo.sv
// Two-entry request FIFO with wrapping pointers; ready is registered from the next count.
module alu4_req_fifo
  import alu4_pkg::*;
#(
  parameter int unsigned DEPTH = ALU4_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  alu4_req_t                  push_data_i,
  input  logic                       pop_i,
  output alu4_req_t                  head_c,
  output logic                       not_empty_c,
  output logic [ALU4_FIFO_CNT_W-1:0] count_nxt_c,
  output logic                       ready_o
);

  alu4_req_t                  mem_q [DEPTH];
  logic [ALU4_FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ALU4_FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ALU4_FIFO_CNT_W-1:0] count_q;
  logic                       ready_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_nxt_c = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + ALU4_FIFO_PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + ALU4_FIFO_PTR_W'(1);
    if (push_i && !pop_i) begin
      count_nxt_c = count_q + ALU4_FIFO_CNT_W'(1);
    end else if (!push_i && pop_i) begin
      count_nxt_c = count_q - ALU4_FIFO_CNT_W'(1);
    end
  end

  // ready is held low through reset and rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_nxt_c;
      ready_q  <= (count_nxt_c != ALU4_FIFO_CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_c      = mem_q[rd_ptr_q];
  assign not_empty_c = (count_q != '0);
  assign ready_o     = ready_q;

endmodule

// File: rtl/alu4_issue_stage.sv
// Issue/retire stage around the 4-bit add/mul/sub unit: FIFO -> operand reg -> result reg.
// Define ALU4_STATS_EN to add per-opcode saturating transfer counters.
module alu4_issue_stage
  import alu4_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = ALU4_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ALU4_OPND_W-1:0] in_a,
  input  logic [ALU4_OPND_W-1:0] in_b,
  input  logic [ALU4_OP_W-1:0]   in_op,
  output logic [ALU4_OPND_W-1:0] alu_a,
  output logic [ALU4_OPND_W-1:0] alu_b,
  output logic [ALU4_OP_W-1:0]   alu_op,
  input  logic [ALU4_RES_W-1:0]  alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ALU4_RES_W-1:0]  out_result,
  output logic [ALU4_OP_W-1:0]   out_op,
  output logic                   busy
`ifdef ALU4_STATS_EN
  ,
  input  logic [ALU4_OP_W-1:0]        stats_sel,
  output logic [ALU4_STATS_CNT_W-1:0] stats_cnt,
  input  logic                        stats_clr
`endif
);

  alu4_req_t                  push_req;
  alu4_req_t                  fifo_head;
  logic                       fifo_not_empty;
  logic [ALU4_FIFO_CNT_W-1:0] fifo_count_nxt;
  logic                       push;
  logic                       s1_adv;
  logic                       s1_load;

  logic                       op_vld_q, op_vld_d;
  alu4_req_t                  s1_q, s1_d;
  logic                       out_valid_q, out_valid_d;
  logic [ALU4_RES_W-1:0]      out_result_q, out_result_d;
  logic [ALU4_OP_W-1:0]       out_op_q, out_op_d;
  logic                       busy_q, busy_d;

  assign push_req = '{a: in_a, b: in_b, op: in_op};
  assign push     = in_valid && in_ready;

  alu4_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_req),
    .pop_i       (s1_load),
    .head_c      (fifo_head),
    .not_empty_c (fifo_not_empty),
    .count_nxt_c (fifo_count_nxt),
    .ready_o     (in_ready)
  );

  // S1 only changes on a load, so the unit's inputs stay stable while idle
  always_comb begin
    s1_adv       = op_vld_q && (!out_valid_q || out_ready);
    s1_load      = fifo_not_empty && (!op_vld_q || s1_adv);
    op_vld_d     = op_vld_q;
    s1_d         = s1_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_op_d     = out_op_q;
    if (s1_load) begin
      op_vld_d = 1'b1;
      s1_d     = fifo_head;
    end else if (s1_adv) begin
      op_vld_d = 1'b0;
    end
    if (s1_adv) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_result;
      out_op_d     = s1_q.op;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
    busy_d = (fifo_count_nxt != '0) || op_vld_d || out_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld_q     <= 1'b0;
      s1_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_op_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      op_vld_q     <= op_vld_d;
      s1_q         <= s1_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_op_q     <= out_op_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_a      = s1_q.a;
  assign alu_b      = s1_q.b;
  assign alu_op     = s1_q.op;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_op     = out_op_q;
  assign busy       = busy_q;

`ifdef ALU4_STATS_EN
  logic [ALU4_STATS_CNT_W-1:0] cnt_q [ALU4_NUM_OPS];
  logic [ALU4_STATS_CNT_W-1:0] cnt_d [ALU4_NUM_OPS];

  // clear takes priority over a same-cycle increment; counters stick at all-ones
  always_comb begin
    for (int unsigned i = 0; i < ALU4_NUM_OPS; i++) cnt_d[i] = cnt_q[i];
    if (stats_clr) begin
      for (int unsigned i = 0; i < ALU4_NUM_OPS; i++) cnt_d[i] = '0;
    end else if (out_valid_q && out_ready && (cnt_q[out_op_q] != '1)) begin
      cnt_d[out_op_q] = cnt_q[out_op_q] + ALU4_STATS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ALU4_NUM_OPS; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < ALU4_NUM_OPS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stats_cnt = cnt_q[stats_sel];
`endif

endmodule

// File: tb/tb_alu4_issue_stage.sv
// Self-checking bench for alu4_issue_stage with a behavioural add/sub/mul unit attached.
module tb_alu4_issue_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [1:0] in_op = '0;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_result;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic [1:0] out_op;
  logic       busy;
`ifdef ALU4_STATS_EN
  logic [1:0] stats_sel = '0;
  logic [7:0] stats_cnt;
  logic       stats_clr = 1'b0;
`endif

  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] sb_q[$];
  logic [9:0] sb_exp;
  logic [7:0] exp_r;
  int         k;

  always #5 clk = ~clk;

  // combinational unit stand-in
  always_comb begin
    case (alu_op)
      2'b11:   alu_result = 8'(alu_a) * 8'(alu_b);
      2'b01:   alu_result = 8'(alu_a) - 8'(alu_b);
      default: alu_result = 8'(alu_a) + 8'(alu_b);
    endcase
  end

  alu4_issue_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .busy       (busy)
`ifdef ALU4_STATS_EN
    ,
    .stats_sel  (stats_sel),
    .stats_cnt  (stats_cnt),
    .stats_clr  (stats_clr)
`endif
  );

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    n_cmp++;
    if ({out_valid, busy} !== 2'b00) begin
      n_err++; $display("FAIL reset_valid_busy: got %b, required 00", {out_valid, busy});
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_op, out_result, out_op} !== 20'h0) begin
      n_err++; $display("FAIL reset_data: got %h, required 0", {alu_a, alu_b, alu_op, out_result, out_op});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %b, required 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_edge: got %b, required 1", in_ready); end
  endtask

  task automatic test_single_mul;
    in_valid = 1'b1; in_a = 4'd7; in_b = 4'd9; in_op = 2'b11; out_ready = 1'b1;
    exp_r = 8'h3F;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) sb_q.push_back({in_op, exp_r});
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++; $display("FAIL single_sb: got %h, required no output", {out_op, out_result});
        end else begin
          sb_exp = sb_q.pop_front();
          if ({out_op, out_result} !== sb_exp) begin
            n_err++; $display("FAIL single_result: got %h, required %h", {out_op, out_result}, sb_exp);
          end
        end
      end
      n_cmp++;
      if (out_valid !== (c == 3)) begin
        n_err++; $display("FAIL single_valid c=%0d: got %b, required %b", c, out_valid, (c == 3));
      end
      if (c == 2) begin
        n_cmp++;
        if ({alu_a, alu_b, alu_op} !== {4'd7, 4'd9, 2'b11}) begin
          n_err++; $display("FAIL single_alu_in: got %h, required %h", {alu_a, alu_b, alu_op}, {4'd7, 4'd9, 2'b11});
        end
      end
      if (c == 1 || c == 4) begin
        n_cmp++;
        if (busy !== (c == 1)) begin
          n_err++; $display("FAIL single_busy c=%0d: got %b, required %b", c, busy, (c == 1));
        end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic test_streaming;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8); in_a = 4'(c); in_b = 4'd15; in_op = 2'b11;
      exp_r = 8'(c * 15);
      @(negedge clk);
      if (in_valid) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready c=%0d: got %b, required 1", c, in_ready); end
      end
      if (in_valid && in_ready) sb_q.push_back({in_op, exp_r});
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++; $display("FAIL stream_sb: got %h, required no output", {out_op, out_result});
        end else begin
          sb_exp = sb_q.pop_front();
          if ({out_op, out_result} !== sb_exp) begin
            n_err++; $display("FAIL stream_result: got %h, required %h", {out_op, out_result}, sb_exp);
          end
        end
      end
      n_cmp++;
      if (out_valid !== (c >= 3 && c <= 10)) begin
        n_err++; $display("FAIL stream_valid c=%0d: got %b, required %b", c, out_valid, (c >= 3 && c <= 10));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_a = 4'(k + 1); in_b = 4'(k + 2);
      in_op = (k == 1) ? 2'b00 : 2'b11;
      exp_r = (k == 1) ? 8'(2 * k + 3) : 8'((k + 1) * (k + 2));
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb_q.push_back({in_op, exp_r});
        k++;
      end
      if (c >= 3) begin
        n_cmp++;
        if ({out_valid, out_op, out_result} !== {1'b1, 2'b11, 8'h02}) begin
          n_err++; $display("FAIL bp_hold c=%0d: got %h, required %h", c, {out_valid, out_op, out_result}, {1'b1, 2'b11, 8'h02});
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (k !== 4) begin n_err++; $display("FAIL bp_accepted: got %0d, required 4", k); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b, required 0", in_ready); end

    // one-cycle out_ready pulse with the FIFO full: pop happens, push does not
    in_a = 4'd5; in_b = 4'd6; in_op = 2'b11; exp_r = 8'd30;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL pulse_ready: got %b, required 0", in_ready); end
    if (in_valid && in_ready) sb_q.push_back({in_op, exp_r});
    if (out_valid && out_ready) begin
      n_cmp++;
      sb_exp = sb_q.pop_front();
      if ({out_op, out_result} !== sb_exp) begin
        n_err++; $display("FAIL pulse_result: got %h, required %h", {out_op, out_result}, sb_exp);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL fifth_ready: got %b, required 1", in_ready); end
    if (in_valid && in_ready) sb_q.push_back({in_op, exp_r});
    @(posedge clk); #1;
    in_valid = 1'b0;

    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++; $display("FAIL drain_sb: got %h, required no output", {out_op, out_result});
        end else begin
          sb_exp = sb_q.pop_front();
          if ({out_op, out_result} !== sb_exp) begin
            n_err++; $display("FAIL drain_result c=%0d: got %h, required %h", c, {out_op, out_result}, sb_exp);
          end
        end
      end
      n_cmp++;
      if (out_valid !== (c < 4)) begin
        n_err++; $display("FAIL drain_valid c=%0d: got %b, required %b", c, out_valid, (c < 4));
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({busy, 1'b0} !== {1'b0, 1'b0} || sb_q.size() != 0) begin
      n_err++; $display("FAIL drain_end: got busy=%b pending=%0d, required busy=0 pending=0", busy, sb_q.size());
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_a = 4'(c + 5); in_b = 4'd3; in_op = 2'b11;
      exp_r = 8'((c + 5) * 3);
      @(negedge clk);
      if (in_valid && in_ready) sb_q.push_back({in_op, exp_r});
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, busy, in_ready} !== 3'b000) begin
      n_err++; $display("FAIL midrst_ctrl: got %b, required 000", {out_valid, busy, in_ready});
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_op} !== 10'h0) begin
      n_err++; $display("FAIL midrst_alu: got %h, required 0", {alu_a, alu_b, alu_op});
    end
    #3;
    rst_n = 1'b1;
    sb_q.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale c=%0d: got %b, required 0", c, out_valid); end
      if (c == 1) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b, required 1", in_ready); end
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef ALU4_STATS_EN
  task automatic test_stats;
    out_ready = 1'b1; stats_sel = 2'd3;
    for (int c = 0; c < 304; c++) begin
      in_valid = (c < 300); in_a = 4'(c % 16); in_b = 4'd15; in_op = 2'b11;
      exp_r = 8'((c % 16) * 15);
      @(negedge clk);
      if (in_valid && in_ready) sb_q.push_back({in_op, exp_r});
      if (out_valid && out_ready) begin
        n_cmp++;
        sb_exp = sb_q.pop_front();
        if ({out_op, out_result} !== sb_exp) begin
          n_err++; $display("FAIL stats_result c=%0d: got %h, required %h", c, {out_op, out_result}, sb_exp);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (stats_cnt !== 8'd255) begin n_err++; $display("FAIL stats_sat: got %0d, required 255", stats_cnt); end
    stats_sel = 2'd0;
    #1;
    n_cmp++;
    if (stats_cnt !== 8'd0) begin n_err++; $display("FAIL stats_add: got %0d, required 0", stats_cnt); end
    stats_sel = 2'd3;

    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 4'd2; in_b = 4'd3; in_op = 2'b11;
    @(negedge clk);
    if (in_valid && in_ready) sb_q.push_back({in_op, 8'd6});
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL stats_wait_valid: got %b, required 1", out_valid); end
    stats_clr = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    if (out_valid && out_ready) begin
      n_cmp++;
      sb_exp = sb_q.pop_front();
      if ({out_op, out_result} !== sb_exp) begin
        n_err++; $display("FAIL stats_clr_result: got %h, required %h", {out_op, out_result}, sb_exp);
      end
    end
    @(posedge clk); #1;
    stats_clr = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (stats_cnt !== 8'd0) begin n_err++; $display("FAIL stats_clr: got %0d, required 0", stats_cnt); end
  endtask
`endif

  initial begin
    test_reset;
    test_single_mul;
    test_streaming;
    test_backpressure;
    test_reset_mid;
`ifdef ALU4_STATS_EN
    test_stats;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
